windowed_count_fsm: RTL

Parametrised successor to the team's fixed 3-cycle "two-of-three" detector. After an arm pulse on s, the block samples w in back-to-back windows of WIN cycles. At the end of each window it compares the count of 1s against TARGET, using a runtime-selectable compare mode. It is used as a generic pattern/qualification monitor downstream of control FSMs, and adds a stop input, a window-done strobe and a saturating hit counter.

---
 rtl/wcfsm_pkg.sv | 27 ++
 rtl/win_counter.sv | 42 ++++
 rtl/windowed_count_fsm.sv | 83 ++++++++
 3 files changed

// File: rtl/wcfsm_pkg.sv
// Shared types, mode constants and the window compare for windowed_count_fsm.
// Combinational helpers only; no latency and no flow control.
// Holds no state.
package wcfsm_pkg;

  localparam logic [1:0] MODE_EQ = 2'd0;
  localparam logic [1:0] MODE_GE = 2'd1;
  localparam logic [1:0] MODE_LE = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counts never exceed 255, so 8 bits of zero-extension preserves the unsigned compare.
  function automatic logic cmp(input logic [7:0] ones, input logic [7:0] target,
                               input logic [1:0] mode);
    logic r;
    case (mode)
      MODE_GE: r = (ones >= target);
      MODE_LE: r = (ones <= target);
      default: r = (ones == target);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/win_counter.sv
// Window position and ones counter; ones_nx/last are combinational from the current state.
// One sample per enabled edge; the counter wraps to zero when a window completes.
// No backpressure: clear has priority over sample_en.
module win_counter #(
  parameter int WIN = 3,
  parameter int CW  = 2,
  parameter int IW  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sample_en,
  input  logic          w,
  output logic          last,
  output logic [CW-1:0] ones_nx,
  output logic [CW-1:0] ones_cnt
);

  logic [IW-1:0] idx;

  assign last    = (idx == IW'(WIN - 1));
  assign ones_nx = ones_cnt + CW'(w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      ones_cnt <= '0;
    end else if (clear) begin
      idx      <= '0;
      ones_cnt <= '0;
    end else if (sample_en) begin
      if (last) begin
        idx      <= '0;
        ones_cnt <= '0;
      end else begin
        idx      <= idx + IW'(1);
        ones_cnt <= ones_nx;
      end
    end
  end

endmodule

// File: rtl/windowed_count_fsm.sv
// Armed monitor counting ones of w over back-to-back WIN-cycle windows and comparing to TARGET.
// z/win_done are registered: one cycle after the last sample of a window.
// No backpressure; stop disarms immediately and drops the partial window.
module windowed_count_fsm
  import wcfsm_pkg::*;
#(
  parameter int WIN    = 3,
  parameter int TARGET = 2,
  parameter int HIT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s,
  input  logic                       stop,
  input  logic                       w,
  input  logic [1:0]                 mode,
  output logic                       z,
  output logic                       win_done,
  output logic [$clog2(WIN+1)-1:0]   ones_cnt,
  output logic [HIT_W-1:0]           hits,
  output logic                       busy
);

  localparam int CW = $clog2(WIN + 1);
  localparam int IW = (WIN > 1) ? $clog2(WIN) : 1;

  if (WIN < 1 || WIN > 255) begin : g_bad_win
    $fatal(1, "windowed_count_fsm: WIN must be in 1..255");
  end
  if (TARGET < 0 || TARGET > WIN) begin : g_bad_target
    $fatal(1, "windowed_count_fsm: TARGET must be in 0..WIN");
  end
  if (HIT_W < 1 || HIT_W > 32) begin : g_bad_hitw
    $fatal(1, "windowed_count_fsm: HIT_W must be in 1..32");
  end

  state_t          state, state_nx;
  logic            sample_en, clear, last, hit;
  logic [CW-1:0]   ones_nx;

  assign busy      = (state == ST_RUN);
  assign sample_en = busy && !stop;
  assign clear     = busy && stop;
  assign hit       = sample_en && last && cmp(8'(ones_nx), 8'(TARGET), mode);

  win_counter #(.WIN(WIN), .CW(CW), .IW(IW)) u_win (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .sample_en(sample_en),
    .w        (w),
    .last     (last),
    .ones_nx  (ones_nx),
    .ones_cnt (ones_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (s)    state_nx = ST_RUN;
      ST_RUN:  if (stop) state_nx = ST_IDLE;
      default:           state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z        <= 1'b0;
      win_done <= 1'b0;
      hits     <= '0;
    end else begin
      z        <= hit;
      win_done <= sample_en && last;
      if (hit && hits != {HIT_W{1'b1}}) hits <= hits + HIT_W'(1);
    end
  end

endmodule
